// File: rtl/add_serial_arb_pkg.sv
// Shared constants, state encodings and helpers for the add_serial round-robin arbiter.
package add_serial_arb_pkg;

  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_ADD_LAT = 9;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned STATE_W     = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] S_CAPT  = 3'd3;
  localparam logic [STATE_W-1:0] S_PARK  = 3'd4;

  // One-hot decode of a requester index; callers truncate to NUM_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/add_serial_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping to 0.
module add_serial_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               found_c
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the closest candidate to rr_ptr wins.
  always_comb begin : p_pick
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_idx_c = '0;
    found_c   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = wrap_add(rr_ptr, 32'(off));
      if (req[cand]) begin
        win_idx_c = cand;
        found_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_serial_arb.sv
// Round-robin arbiter/sequencer sharing one bit-serial adder among NUM_REQ requesters.
module add_serial_arb
  import add_serial_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] op_a,
  input  logic [NUM_REQ*W-1:0] op_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         rsp_sum,
  output logic                 busy,
  output logic                 adder_en,
  output logic [W-1:0]         adder_a,
  output logic [W-1:0]         adder_b,
  input  logic [W-1:0]         adder_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

  logic [STATE_W-1:0] state, state_d;
  logic [NUM_REQ-1:0] gnt_d, rsp_valid_d;
  logic [W-1:0]       rsp_sum_d, adder_a_d, adder_b_d;
  logic               busy_d, adder_en_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   win_idx, win_idx_d;
  logic [CNT_W-1:0]   lat_cnt, lat_cnt_d;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_found_c;

  add_serial_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .win_idx_c (pick_idx_c),
    .found_c   (pick_found_c)
  );

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      busy      <= 1'b0;
      adder_en  <= 1'b0;
      adder_a   <= '0;
      adder_b   <= '0;
      rr_ptr    <= '0;
      win_idx   <= '0;
      lat_cnt   <= '0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_sum   <= rsp_sum_d;
      busy      <= busy_d;
      adder_en  <= adder_en_d;
      adder_a   <= adder_a_d;
      adder_b   <= adder_b_d;
      rr_ptr    <= rr_ptr_d;
      win_idx   <= win_idx_d;
      lat_cnt   <= lat_cnt_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum;
    adder_en_d  = 1'b0;
    adder_a_d   = adder_a;
    adder_b_d   = adder_b;
    rr_ptr_d    = rr_ptr;
    win_idx_d   = win_idx;
    lat_cnt_d   = lat_cnt;

    case (state)
      S_IDLE: begin
        if (pick_found_c) begin
          state_d    = S_ISSUE;
          gnt_d      = NUM_REQ'(onehot(3'(pick_idx_c)));
          adder_a_d  = op_a[32'(pick_idx_c) * W +: W];
          adder_b_d  = op_b[32'(pick_idx_c) * W +: W];
          win_idx_d  = pick_idx_c;
          adder_en_d = 1'b1;
          lat_cnt_d  = '0;
        end
      end
      S_ISSUE: begin
        state_d   = S_WAIT;
        lat_cnt_d = CNT_W'(1);
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt + CNT_W'(1);
        if (lat_cnt == CNT_W'(ADD_LAT - 1)) state_d = S_CAPT;
      end
      S_CAPT: begin
        rsp_sum_d   = adder_out;
        rsp_valid_d = NUM_REQ'(onehot(3'(win_idx)));
        state_d     = S_PARK;
      end
      S_PARK: begin
        // Adder enable stays low here so the serial adder drops back to its idle state.
        gnt_d    = '0;
        rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        gnt_d     = '0;
        rsp_sum_d = '0;
        adder_a_d = '0;
        adder_b_d = '0;
        win_idx_d = '0;
        lat_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_add_serial_arb.sv
// Directed self-checking bench for add_serial_arb with a behavioural serial-adder model.
module tb_add_serial_arb;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int LAT = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] op_a, op_b;
  logic [NR-1:0]   gnt, rsp_valid;
  logic [W-1:0]    rsp_sum, adder_a, adder_b, adder_out;
  logic            busy, adder_en;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  add_serial_arb #(.NUM_REQ(NR), .W(W), .ADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .adder_en  (adder_en),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_out (adder_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: result valid only in cycles 9 and 10 counting the enable cycle as 1.
  logic [3:0] acnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      acnt <= '0;
    else if (adder_en)               acnt <= 4'd1;
    else if (acnt != 0 && acnt != 15) acnt <= acnt + 4'd1;
  end
  assign adder_out = (acnt == 4'd8 || acnt == 4'd9) ? W'(adder_a + adder_b) : 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [NR-1:0] g, output int t);
    g = '0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt != 0) begin
        g = gnt;
        t = cyc;
        break;
      end
    end
    chk("gnt_seen", 32'(g != 0), 32'd1);
  endtask

  // Called on the first cycle gnt is high; follows the operation to the IDLE cycle.
  task automatic run_op(input int idx, input logic [7:0] exp_sum, input int drop_k,
                        input bit release_req);
    int            en_cnt, rv_k, rv_cnt;
    logic [NR-1:0] rv_seen, oh;
    logic [7:0]    sum_seen;
    oh       = NR'(1) << idx;
    en_cnt   = adder_en ? 1 : 0;
    rv_k     = 0;
    rv_cnt   = 0;
    rv_seen  = '0;
    sum_seen = '0;
    for (int k = 2; k <= 11; k++) begin
      step();
      if (k == drop_k) begin
        req[idx]          = 1'b0;
        op_b[idx*W +: W]  = 8'hFF;
      end
      if (adder_en) en_cnt++;
      if (rsp_valid != 0) begin
        rv_cnt++;
        if (rv_k == 0) begin
          rv_k     = k;
          rv_seen  = rsp_valid;
          sum_seen = rsp_sum;
        end
        if (release_req) req[idx] = 1'b0;
      end
    end
    chk("adder_en_pulses", en_cnt, 1);
    chk("rsp_latency", rv_k, 11);
    chk("rsp_index", rv_seen, oh);
    chk("rsp_sum", sum_seen, exp_sum);
    step();
    chk("rsp_pulse_width", 32'(rv_cnt + (rsp_valid != 0 ? 1 : 0)), 1);
    chk("gnt_cleared", gnt, 0);
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g;
    int            t, tprev;
    logic [7:0]    exp_sum [NR];
    int            ord [6];

    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adder_en", adder_en, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_adder_a", adder_a, 0);
    chk("rst_adder_b", adder_b, 0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt", gnt, 0);

    // Single requester 2: 3C + 05 = 41.
    op_a[23:16] = 8'h3C;
    op_b[23:16] = 8'h05;
    req         = 4'b0100;
    wait_gnt(g, t);
    chk("single_gnt", g, 4'b0100);
    chk("single_adder_a", adder_a, 8'h3C);
    chk("single_adder_b", adder_b, 8'h05);
    chk("single_busy", busy, 1);
    run_op(2, 8'h41, 0, 1'b1);

    // rr_ptr=3: requester 3 beats 0, then wrap to 0 with overflow FF + 02 = 01.
    op_a[31:24] = 8'h10;
    op_b[31:24] = 8'h20;
    op_a[7:0]   = 8'hFF;
    op_b[7:0]   = 8'h02;
    req         = 4'b1001;
    wait_gnt(g, t);
    chk("ptr3_gnt", g, 4'b1000);
    run_op(3, 8'h30, 0, 1'b1);
    wait_gnt(g, t);
    chk("wrap_gnt", g, 4'b0001);
    run_op(0, 8'h01, 0, 1'b1);

    // Requester 1 wins over 3; drops req and changes op_b three cycles after grant.
    op_a[15:8]  = 8'h11;
    op_b[15:8]  = 8'h22;
    op_a[31:24] = 8'h40;
    op_b[31:24] = 8'h41;
    req         = 4'b1010;
    wait_gnt(g, t);
    chk("drop_gnt", g, 4'b0010);
    run_op(1, 8'h33, 4, 1'b1);
    wait_gnt(g, t);
    chk("after_drop_gnt", g, 4'b1000);
    run_op(3, 8'h81, 0, 1'b1);

    // All four held from reset release.
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      op_a[i*W +: W] = 8'(i * 16 + 1);
      op_b[i*W +: W] = 8'(i + 2);
    end
    exp_sum = '{8'h03, 8'h14, 8'h25, 8'h36};
    ord     = '{0, 1, 2, 3, 0, 1};
    req     = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    tprev = 0;
    for (int n = 0; n < 6; n++) begin
      wait_gnt(g, t);
      chk("rr_order", g, NR'(1) << ord[n]);
      if (n > 0) chk("grant_spacing", t - tprev, 12);
      tprev = t;
      run_op(ord[n], exp_sum[ord[n]], 0, 1'b0);
    end

    // Reset during WAIT of requester 2 (rr_ptr=2 at that point).
    wait_gnt(g, t);
    chk("pre_rst_gnt", g, 4'b0100);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_adder_en", adder_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    req = 4'b0110;
    step();
    step();
    rst_n = 1'b1;
    wait_gnt(g, t);
    chk("post_rst_gnt", g, 4'b0010);
    run_op(1, 8'h14, 0, 1'b1);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
